// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS pattern generator and its matching checker:
// mode encoding, per-polynomial width/tap constants and the reseed value.
package prbs_pkg;

  typedef enum logic [2:0] {
    MODE_PRBS7  = 3'd0,
    MODE_PRBS9  = 3'd1,
    MODE_PRBS15 = 3'd2,
    MODE_PRBS23 = 3'd3,
    MODE_PRBS31 = 3'd4,
    MODE_ALT    = 3'd5,
    MODE_ZERO_A = 3'd6,
    MODE_ZERO_B = 3'd7
  } prbs_mode_e;

  localparam int unsigned LFSR_W = 31;

  // W is the polynomial degree, T the second tap (x^W + x^T + 1)
  localparam int unsigned PRBS7_W  = 7;
  localparam int unsigned PRBS7_T  = 6;
  localparam int unsigned PRBS9_W  = 9;
  localparam int unsigned PRBS9_T  = 5;
  localparam int unsigned PRBS15_W = 15;
  localparam int unsigned PRBS15_T = 14;
  localparam int unsigned PRBS23_W = 23;
  localparam int unsigned PRBS23_T = 18;
  localparam int unsigned PRBS31_W = 31;
  localparam int unsigned PRBS31_T = 28;

  // All-ones covers the low W bits of every polynomial and starts MODE_ALT at phase 1
  localparam logic [LFSR_W-1:0] PRBS_SEED = '1;

  function automatic logic is_lfsr_mode(input prbs_mode_e m);
    return (m <= MODE_PRBS31);
  endfunction

endpackage

// File: rtl/lfsr_prbs_step.sv
// Combinational DATA_WIDTH-bit advance of the 31-bit pattern state; bits_out[0]
// is the first generated bit. Shared with the far-end checker.
module lfsr_prbs_step
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  prbs_mode_e              mode,
  input  logic [LFSR_W-1:0]       state_in,
  output logic [LFSR_W-1:0]       state_out,
  output logic [DATA_WIDTH-1:0]   bits_out
);

  logic [LFSR_W-1:0] s_work;
  logic              nb;

  always_comb begin
    s_work   = state_in;
    nb       = 1'b0;
    bits_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (mode)
        MODE_PRBS7:  nb = s_work[PRBS7_W-1]  ^ s_work[PRBS7_T-1];
        MODE_PRBS9:  nb = s_work[PRBS9_W-1]  ^ s_work[PRBS9_T-1];
        MODE_PRBS15: nb = s_work[PRBS15_W-1] ^ s_work[PRBS15_T-1];
        MODE_PRBS23: nb = s_work[PRBS23_W-1] ^ s_work[PRBS23_T-1];
        MODE_PRBS31: nb = s_work[PRBS31_W-1] ^ s_work[PRBS31_T-1];
        MODE_ALT:    nb = s_work[0];
        default:     nb = 1'b0;
      endcase
      bits_out[i] = nb;
      // The alternating pattern keeps its phase in bit 0 so it runs on across words
      if (is_lfsr_mode(mode)) begin
        s_work = {s_work[LFSR_W-2:0], nb};
      end else if (mode == MODE_ALT) begin
        s_work[0] = ~s_work[0];
      end
    end
    state_out = s_work;
  end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Multi-pattern PRBS generator with valid/ready output, word-aligned reseed and
// optional single-bit error injection (enabled by defining PRBS_GEN_ERR_INJ_EN).
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REVERSE    = 0,
  parameter int INVERT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            mode,
  input  logic                  reseed,
  input  logic                  inject_err,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           inj_count
);

  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  prbs_mode_e            active_mode_q, active_mode_d;
  logic                  reseed_pend_q, reseed_pend_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                  load;
  logic [LFSR_W-1:0]     step_start, step_next;
  logic [DATA_WIDTH-1:0] gen_bits, ordered_bits, shaped_word, final_word;

  // A held word blocks loading until it is accepted
  assign load       = enable && (!m_valid_q || m_ready);
  assign step_start = reseed_pend_q ? PRBS_SEED : lfsr_q;

  lfsr_prbs_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .mode      (active_mode_q),
    .state_in  (step_start),
    .state_out (step_next),
    .bits_out  (gen_bits)
  );

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
    if (REVERSE != 0) begin : g_lsb_first
      assign ordered_bits[gi] = gen_bits[gi];
    end else begin : g_msb_first
      assign ordered_bits[gi] = gen_bits[DATA_WIDTH-1-gi];
    end
  end

  assign shaped_word = (INVERT != 0) ? ~ordered_bits : ordered_bits;

`ifdef PRBS_GEN_ERR_INJ_EN
  logic        inj_pend_q, inj_pend_d;
  logic [15:0] inj_count_q, inj_count_d;
  logic        inj_fire;

  // A pulse arriving with a load corrupts that very word
  assign inj_fire = load && (inj_pend_q || inject_err);

  always_comb begin
    final_word    = shaped_word;
    final_word[0] = shaped_word[0] ^ inj_fire;
  end

  always_comb begin
    inj_pend_d  = inj_pend_q;
    inj_count_d = inj_count_q;
    if (inj_fire) begin
      inj_pend_d = 1'b0;
      if (inj_count_q != 16'hFFFF) begin
        inj_count_d = inj_count_q + 16'd1;
      end
    end else if (inject_err) begin
      inj_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_pend_q  <= 1'b0;
      inj_count_q <= 16'd0;
    end else begin
      inj_pend_q  <= inj_pend_d;
      inj_count_q <= inj_count_d;
    end
  end

  assign inj_count = inj_count_q;
`else
  logic unused_inject_err;
  assign unused_inject_err = inject_err;
  assign final_word        = shaped_word;
  assign inj_count         = 16'd0;
`endif

  always_comb begin
    lfsr_d        = lfsr_q;
    active_mode_d = active_mode_q;
    reseed_pend_d = reseed_pend_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    if (load) begin
      lfsr_d        = step_next;
      m_data_d      = final_word;
      m_valid_d     = 1'b1;
      reseed_pend_d = 1'b0;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    // Requests seen this cycle only take effect at the following load
    if (mode != active_mode_q) begin
      active_mode_d = prbs_mode_e'(mode);
      reseed_pend_d = 1'b1;
    end
    if (reseed) begin
      reseed_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q        <= PRBS_SEED;
      active_mode_q <= MODE_PRBS7;
      reseed_pend_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      active_mode_q <= active_mode_d;
      reseed_pend_q <= reseed_pend_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule
